// File: rtl/pipelined_approx_adder.sv
// pipelined_approx_adder: WIDTH-bit adder. The low ke bits are approximated with OR.
// The remaining bits form an exact ripple chain. The adder is split into STAGES segments.
// Each segment is resolved in its own pipeline stage, with valid/ready backpressure.
// Optional feature macro: PIPELINED_APPROX_ADDER_ERRDIST_EN. It adds the ErrDist output,
// which is the absolute distance between the exact and the approximate result.
module pipelined_approx_adder #(
    parameter int WIDTH  = 16,
    parameter int STAGES = 2,
    parameter int KW     = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             InValid,
    output logic             InReady,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    input  logic [KW-1:0]    ApproxBits,
    output logic             OutValid,
    input  logic             OutReady,
    output logic [WIDTH-1:0] Sum,
    output logic             Cout
`ifdef PIPELINED_APPROX_ADDER_ERRDIST_EN
    ,
    output logic [WIDTH:0]   ErrDist
`endif
);

    localparam int SEG = WIDTH / STAGES;

    // Clamp the requested approximate width to the operand width.
    function automatic logic [KW-1:0] clamp_k(input logic [KW-1:0] k);
        return (int'(k) > WIDTH) ? KW'(WIDTH) : k;
    endfunction

    // Resolve one segment whose lowest bit sits at absolute position base.
    // Below ke, a bit is A|B and emits A&B as its carry. The carry out of bit ke-1 therefore
    // becomes the carry into the exact part, or Cout when ke = WIDTH. The result is {carry_out, sum}.
    function automatic logic [SEG:0] seg_add(input logic [SEG-1:0] a,
                                             input logic [SEG-1:0] b,
                                             input logic           ci,
                                             input logic [KW-1:0]  ke,
                                             input int             base);
        logic           c;
        logic [SEG-1:0] s;
        c = ci;
        s = '0;
        for (int j = 0; j < SEG; j++) begin
            if (base + j < int'(ke)) begin
                s[j] = a[j] | b[j];
                c    = a[j] & b[j];
            end else begin
                s[j] = a[j] ^ b[j] ^ c;
                c    = (a[j] & b[j]) | (c & (a[j] ^ b[j]));
            end
        end
        return {c, s};
    endfunction

    logic              adv;
    logic [STAGES-1:0] vld_p;
    logic [STAGES-1:0] nxt_vld;
    logic [WIDTH-1:0]  a_p     [STAGES];
    logic [WIDTH-1:0]  b_p     [STAGES];
    logic [WIDTH-1:0]  sum_p   [STAGES];
    logic              cy_p    [STAGES];
    logic [KW-1:0]     ke_p    [STAGES];
    logic [WIDTH-1:0]  nxt_a   [STAGES];
    logic [WIDTH-1:0]  nxt_b   [STAGES];
    logic [WIDTH-1:0]  nxt_sum [STAGES];
    logic              nxt_cy  [STAGES];
    logic [KW-1:0]     nxt_ke  [STAGES];

    // The whole pipeline moves together. It stalls only when the output holds an unaccepted result.
    assign adv      = ~vld_p[STAGES-1] | OutReady;
    assign InReady  = adv;
    assign OutValid = vld_p[STAGES-1];

    // Per-stage next values: stage 0 resolves segment 0 from the ports, and stage s resolves segment s.
    always_comb begin
        logic [SEG:0] r;
        nxt_vld    = '0;
        nxt_vld[0] = InValid;
        nxt_a[0]   = A;
        nxt_b[0]   = B;
        nxt_ke[0]  = clamp_k(ApproxBits);
        r          = seg_add(A[SEG-1:0], B[SEG-1:0], Cin, nxt_ke[0], 0);
        nxt_sum[0] = '0;
        nxt_sum[0][SEG-1:0] = r[SEG-1:0];
        nxt_cy[0]  = r[SEG];
        for (int s = 1; s < STAGES; s++) begin
            nxt_vld[s] = vld_p[s-1];
            nxt_a[s]   = a_p[s-1];
            nxt_b[s]   = b_p[s-1];
            nxt_ke[s]  = ke_p[s-1];
            r          = seg_add(a_p[s-1][s*SEG +: SEG], b_p[s-1][s*SEG +: SEG],
                                 cy_p[s-1], ke_p[s-1], s * SEG);
            nxt_sum[s] = sum_p[s-1];
            nxt_sum[s][s*SEG +: SEG] = r[SEG-1:0];
            nxt_cy[s]  = r[SEG];
        end
    end

    // Stage valids and the output result clear asynchronously, so in-flight beats are discarded.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p <= '0;
            Sum   <= '0;
            Cout  <= 1'b0;
        end else if (adv) begin
            vld_p <= nxt_vld;
            Sum   <= nxt_sum[STAGES-1];
            Cout  <= nxt_cy[STAGES-1];
        end
    end

    // Operand, partial-sum, carry and ke registers are data only and are qualified by the stage valids.
    always_ff @(posedge clk) begin
        if (adv) begin
            for (int s = 0; s < STAGES; s++) begin
                a_p[s]   <= nxt_a[s];
                b_p[s]   <= nxt_b[s];
                sum_p[s] <= nxt_sum[s];
                cy_p[s]  <= nxt_cy[s];
                ke_p[s]  <= nxt_ke[s];
            end
        end
    end

`ifdef PIPELINED_APPROX_ADDER_ERRDIST_EN
    function automatic logic [WIDTH:0] abs_diff(input logic [WIDTH:0] x, input logic [WIDTH:0] y);
        return (x >= y) ? (x - y) : (y - x);
    endfunction

    logic [WIDTH:0] ex_p   [STAGES];
    logic [WIDTH:0] nxt_ex [STAGES];
    logic [WIDTH:0] ex_q;

    // The exact sum is formed at entry and carried alongside the beat.
    always_comb begin
        nxt_ex[0] = {1'b0, A} + {1'b0, B} + {{WIDTH{1'b0}}, Cin};
        for (int s = 1; s < STAGES; s++) begin
            nxt_ex[s] = ex_p[s-1];
        end
    end

    // The exact-sum pipeline advances in lockstep with the approximate stages.
    always_ff @(posedge clk) begin
        if (adv) begin
            for (int s = 0; s < STAGES; s++) begin
                ex_p[s] <= nxt_ex[s];
            end
        end
    end

    // Output-aligned copy of the exact sum. It clears with Sum/Cout, so ErrDist resets to 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_q <= '0;
        end else if (adv) begin
            ex_q <= nxt_ex[STAGES-1];
        end
    end

    assign ErrDist = abs_diff(ex_q, {Cout, Sum});
`endif

endmodule
